line_drawer: RTL and testbench
==============================

LINE_DRAWER -- requirements
Module: line_drawer

Interface
REQ-001 SHALL have parameter HOR_ACTIVE_PIXELS, default 640: screen width; X_WIDTH = $clog2(HOR_ACTIVE_PIXELS).
REQ-002 SHALL have parameter VER_ACTIVE_PIXELS, default 480: screen height; Y_WIDTH = $clog2(VER_ACTIVE_PIXELS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to draw a line; sampled only while ready=1.
REQ-006 SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-007 SHALL have ports x1, x2, input, X_WIDTH bits each: line start and end x.
REQ-008 SHALL have ports y1, y2, input, Y_WIDTH bits each: line start and end y.
REQ-009 SHALL have ports pixel_x and pixel_y, outputs, X_WIDTH and Y_WIDTH bits: the current pixel coordinate.
REQ-010 SHALL have port pixel_valid, output, 1 bit: pixel_x/pixel_y hold a pixel to be written.
REQ-011 SHALL have port pixel_ready, input, 1 bit: the framebuffer writer accepts the pixel; transfer occurs when pixel_valid & pixel_ready.

Function
REQ-012 SHALL implement the FSM states IDLE, SETUP and DRAW; ready=1 exactly in IDLE.
REQ-013 In IDLE, when start=1, SHALL latch x1/y1/x2/y2 and go to SETUP the next cycle, so ready=0 the cycle after start is sampled.
REQ-014 SETUP SHALL last exactly one cycle and compute dx=|x2-x1|, dy=-|y2-y1|, sx=(x1<x2)?+1:-1, sy=(y1<y2)?+1:-1, err=dx+dy.
REQ-015 Signed dx, dy, err and e2 SHALL be max(X_WIDTH,Y_WIDTH)+2 bits wide; no intermediate overflow is permitted for any in-range coordinates.
REQ-016 On leaving SETUP, SHALL load pixel_x=x1 and pixel_y=y1 and assert pixel_valid, so the first pixel is valid 2 cycles after start is sampled.
REQ-017 In DRAW, on each transfer, if (pixel_x,pixel_y)==(x2,y2) SHALL deassert pixel_valid and return to IDLE; ready=1 in the next cycle.
REQ-018 Otherwise, on each transfer SHALL compute e2=2*err; if e2>=dy then err+=dy and pixel_x+=sx; if e2<=dx then err+=dx and pixel_y+=sy; both updates apply in the same cycle when both conditions hold.
REQ-019 While pixel_valid=1 and pixel_ready=0, pixel_x, pixel_y, pixel_valid and err SHALL hold unchanged.
REQ-020 Throughput SHALL be one pixel per cycle while pixel_ready=1; a line emits exactly max(dx,-dy)+1 pixels, endpoints inclusive.
REQ-021 start SHALL be ignored in SETUP and DRAW; input changes after latching SHALL NOT affect the line in progress.
REQ-022 A zero-length line (x1==x2, y1==y2) SHALL emit exactly one pixel.
REQ-023 Coordinates SHALL be passed through without clipping; pixel_x/pixel_y SHALL stay within the closed range between the two endpoints.
REQ-024 pixel_valid SHALL be 0 in IDLE and SETUP.

Reset
REQ-025 rst=1 SHALL, at the next posedge, force state IDLE, ready=1, pixel_valid=0, pixel_x=0, pixel_y=0 and err=0; rst takes priority over start.
REQ-026 rst asserted mid-line SHALL abandon the line with no further pixels; a start after rst deasserts SHALL draw a new line normally.

Verification
REQ-027 Point: start with (5,5)->(5,5), pixel_ready=1 -> exactly one pixel (5,5) at cycle start+2; ready=1 at start+3.
REQ-028 Shallow: start with (0,0)->(3,1), pixel_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1) on consecutive cycles from start+2.
REQ-029 Steep reversed: start with (10,20)->(7,10) -> 11 pixels, y stepping 20 down to 10 by 1 per pixel, x nonincreasing from 10, last pixel (7,10).
REQ-030 Backpressure: (0,240)->(7,240) with pixel_ready high 1 cycle in 3 -> same 8 pixels x=0..7 in order; outputs stable while stalled; no pixel lost or duplicated.
REQ-031 Busy/reset: a second start during DRAW is ignored; rst after the 3rd pixel of (0,0)->(9,0) -> pixel_valid=0 and ready=1 next cycle; a following start of (1,1)->(2,2) emits (1,1),(2,2).

Source files
------------

// File: rtl/line_drawer.sv
// line_drawer: Bresenham line rasterizer streaming one pixel per cycle over a valid/ready handshake.
module line_drawer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_valid,
  input  logic               pixel_ready
);
  localparam int W = (X_WIDTH > Y_WIDTH ? X_WIDTH : Y_WIDTH) + 2;
  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
  state_t state, state_next;
  logic [X_WIDTH-1:0] lx1, lx2;
  logic [Y_WIDTH-1:0] ly1, ly2;
  logic signed [W-1:0] dx, dy, err, e2, dx_c, dy_c, err_step;
  logic sx_neg, sy_neg, fire, at_end, step_x, step_y;
  assign ready = state == IDLE;
  assign pixel_valid = state == DRAW;
  always_comb begin
    fire = pixel_valid & pixel_ready;
    at_end = pixel_x == lx2 && pixel_y == ly2;
    dx_c = lx2 > lx1 ? W'(lx2) - W'(lx1) : W'(lx1) - W'(lx2);
    dy_c = ly2 > ly1 ? W'(ly1) - W'(ly2) : W'(ly2) - W'(ly1);
    e2 = err <<< 1;
    step_x = e2 >= dy;
    step_y = e2 <= dx;
    err_step = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    state_next = state == IDLE  ? (start ? SETUP : IDLE) :
                 state == SETUP ? DRAW :
                 (fire && at_end) ? IDLE : DRAW;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x <= '0;
      pixel_y <= '0;
      err <= '0;
    end else begin
      if (ready && start) begin
        lx1 <= x1;
        ly1 <= y1;
        lx2 <= x2;
        ly2 <= y2;
      end
      if (state == SETUP) begin
        dx <= dx_c;
        dy <= dy_c;
        err <= dx_c + dy_c;
        sx_neg <= lx1 >= lx2;
        sy_neg <= ly1 >= ly2;
        pixel_x <= lx1;
        pixel_y <= ly1;
      end
      // Final pixel leaves coordinates parked on the endpoint.
      if (fire && !at_end) begin
        err <= err_step;
        if (step_x) pixel_x <= sx_neg ? pixel_x - 1'b1 : pixel_x + 1'b1;
        if (step_y) pixel_y <= sy_neg ? pixel_y - 1'b1 : pixel_y + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer: directed checks of line_drawer pixel sequences, timing, backpressure and reset.
module tb_line_drawer;
  logic clk = 0, rst, start, ready, pixel_valid, pixel_ready;
  logic [9:0] x1, x2, pixel_x;
  logic [8:0] y1, y2, pixel_y;
  int checks = 0, errors = 0;
  int qx[$], qy[$];
  int ex[$], ey[$];
  int cycles;

  line_drawer dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .x1(x1), .x2(x2), .y1(y1), .y2(y2),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a line, scrambles the inputs once latched, then collects transferred
  // pixels with pixel_ready high one cycle in every `period`.
  task automatic draw(input int ax1, input int ay1, input int ax2, input int ay2, input int period);
    bit done = 0, held = 0;
    int hx = 0, hy = 0;
    qx.delete();
    qy.delete();
    cycles = 0;
    @(negedge clk);
    x1 = 10'(ax1); y1 = 9'(ay1); x2 = 10'(ax2); y2 = 9'(ay2);
    start = 1;
    pixel_ready = (period == 1);
    @(negedge clk);
    start = 0;
    x1 = 10'd600; y1 = 9'd400; x2 = 10'd1; y2 = 9'd2;
    check("setup_ready", ready, 0);
    check("setup_valid", pixel_valid, 0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
        break;
      end
      cycles++;
      if (k == 0) check("first_valid", pixel_valid, 1);
      if (held) begin
        check("stall_x", pixel_x, hx);
        check("stall_y", pixel_y, hy);
        check("stall_valid", pixel_valid, 1);
      end
      pixel_ready = (cycles % period) == 0;
      if (pixel_valid && pixel_ready) begin
        qx.push_back(int'(pixel_x));
        qy.push_back(int'(pixel_y));
      end
      held = pixel_valid && !pixel_ready;
      hx = pixel_x;
      hy = pixel_y;
    end
    if (!done) check("timeout", 0, 1);
    pixel_ready = 1;
  endtask

  task automatic cmp_line(input string tag);
    check($sformatf("%s_count", tag), qx.size(), ex.size());
    for (int i = 0; i < ex.size() && i < qx.size(); i++) begin
      check($sformatf("%s_x%0d", tag, i), qx[i], ex[i]);
      check($sformatf("%s_y%0d", tag, i), qy[i], ey[i]);
    end
  endtask

  initial begin
    rst = 1; start = 0; pixel_ready = 1;
    x1 = 0; y1 = 0; x2 = 0; y2 = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", pixel_valid, 0);
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    rst = 0;

    draw(5, 5, 5, 5, 1);
    ex = '{5}; ey = '{5};
    cmp_line("point");
    check("point_cycles", cycles, 1);

    draw(0, 0, 3, 1, 1);
    ex = '{0, 1, 2, 3}; ey = '{0, 0, 1, 1};
    cmp_line("shallow");
    check("shallow_cycles", cycles, 4);

    draw(10, 20, 7, 10, 1);
    ex = '{10, 10, 9, 9, 9, 8, 8, 8, 8, 7, 7};
    ey = '{20, 19, 18, 17, 16, 15, 14, 13, 12, 11, 10};
    cmp_line("steep");

    draw(0, 240, 7, 240, 3);
    ex = '{0, 1, 2, 3, 4, 5, 6, 7};
    ey = '{240, 240, 240, 240, 240, 240, 240, 240};
    cmp_line("bp");

    @(negedge clk);
    x1 = 0; y1 = 0; x2 = 9; y2 = 0;
    start = 1;
    pixel_ready = 1;
    @(negedge clk);
    x1 = 50; y1 = 50; x2 = 60; y2 = 60;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("busy_x%0d", i), pixel_x, i);
      check($sformatf("busy_y%0d", i), pixel_y, 0);
      check($sformatf("busy_v%0d", i), pixel_valid, 1);
    end
    @(negedge clk);
    check("busy_x3", pixel_x, 3);
    rst = 1;
    pixel_ready = 0;
    @(negedge clk);
    rst = 0;
    start = 0;
    pixel_ready = 1;
    check("mid_rst_valid", pixel_valid, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_x", pixel_x, 0);
    @(negedge clk);
    check("post_rst_idle", ready, 1);

    draw(1, 1, 2, 2, 1);
    ex = '{1, 2}; ey = '{1, 2};
    cmp_line("diag");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
